// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit
//   Hazard control for the 5-stage pipeline. It also tracks one
//   non-pipelined, multi-cycle MUL/DIV unit.
//   - EX-stage operand forwarding. MEM has priority over WB.
//   - Load-use stall and branch/jump flush.
//   - Per-register pending scoreboard for in-flight long ops.
//     Decode stalls on RAW and WAW against these, and on a structural
//     conflict for the busy unit.
//   - Latency down-counter. On terminal count it issues a one-cycle
//     completion pulse that drives the MUL/DIV regfile write port.
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   rs1_d, rs2_d, rd_d              decode-stage register addresses
//   uses_rs1_d, uses_rs2_d          decode instruction reads rs1 / rs2
//   reg_write_d, muldiv_d           decode writes rd / is a MUL/DIV
//   rs1_e, rs2_e, rd_e              EX-stage register addresses
//   mem_read_e, muldiv_start_e      EX is a load / issues a MUL/DIV
//   rd_m, reg_write_m               MEM-stage destination / write enable
//   rd_w, reg_write_w               WB-stage destination / write enable
//   pc_src_e                        branch/jump taken in EX
//   forward_a, forward_b            00 regfile, 10 MEM, 01 WB
//   stall_f, stall_d                hold PC / IF-ID
//   flush_d, flush_e                bubble IF-ID / ID-EX
//   muldiv_busy                     long-op unit occupied
//   muldiv_wb_valid, muldiv_wb_rd   completion pulse and its destination
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | long-op unit free; cnt parked at 0
// BUSY  | op in flight; cnt counts down and completes when cnt == 0
module hazard_scoreboard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_REGS   = 32,
    parameter int MULDIV_LAT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic                  uses_rs1_d,
    input  logic                  uses_rs2_d,
    input  logic [REG_ADDR_W-1:0] rd_d,
    input  logic                  reg_write_d,
    input  logic                  muldiv_d,
    input  logic [REG_ADDR_W-1:0] rs1_e,
    input  logic [REG_ADDR_W-1:0] rs2_e,
    input  logic [REG_ADDR_W-1:0] rd_e,
    input  logic                  mem_read_e,
    input  logic                  muldiv_start_e,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic                  reg_write_m,
    input  logic [REG_ADDR_W-1:0] rd_w,
    input  logic                  reg_write_w,
    input  logic                  pc_src_e,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic                  muldiv_busy,
    output logic                  muldiv_wb_valid,
    output logic [REG_ADDR_W-1:0] muldiv_wb_rd
);

    localparam int              CNT_W    = $clog2(MULDIV_LAT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LAT - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [REG_ADDR_W-1:0]   wb_rd, wb_rd_nxt;
    logic [NUM_REGS-1:0]     pend, pend_nxt;
    logic                    start_ok;
    logic                    lu, sb, st, stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            wb_rd <= '0;
            pend  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            wb_rd <= wb_rd_nxt;
            pend  <= pend_nxt;
        end
    end

    assign muldiv_busy     = (state == BUSY);
    assign muldiv_wb_valid = (state == BUSY) && (cnt == '0);
    assign muldiv_wb_rd    = wb_rd;

    // The unit can accept a new op when idle or in its completion cycle.
    assign start_ok = muldiv_start_e && (!muldiv_busy || muldiv_wb_valid);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wb_rd_nxt = wb_rd;
        case (state)
            IDLE: begin
                if (muldiv_start_e) begin
                    state_nxt = BUSY;
                    cnt_nxt   = CNT_LOAD;
                    wb_rd_nxt = rd_e;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    if (muldiv_start_e) begin
                        cnt_nxt   = CNT_LOAD;
                        wb_rd_nxt = rd_e;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Clear before set, so a completion and a restart on the same rd
    // leave the bit pending.
    always_comb begin
        pend_nxt = pend;
        if (muldiv_wb_valid)
            pend_nxt[wb_rd] = 1'b0;
        if (start_ok && rd_e != '0)
            pend_nxt[rd_e] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    always_comb begin
        forward_a = 2'b00;
        forward_b = 2'b00;
        if (reg_write_m && rd_m != '0 && rd_m == rs1_e)
            forward_a = 2'b10;
        else if (reg_write_w && rd_w != '0 && rd_w == rs1_e)
            forward_a = 2'b01;
        if (reg_write_m && rd_m != '0 && rd_m == rs2_e)
            forward_b = 2'b10;
        else if (reg_write_w && rd_w != '0 && rd_w == rs2_e)
            forward_b = 2'b01;
    end

    assign lu = mem_read_e && (rd_e != '0) &&
                ((uses_rs1_d && rs1_d == rd_e) || (uses_rs2_d && rs2_d == rd_e));
    assign sb = (uses_rs1_d && pend[rs1_d]) || (uses_rs2_d && pend[rs2_d]) ||
                (reg_write_d && rd_d != '0 && pend[rd_d]);
    assign st = muldiv_d && muldiv_busy && !muldiv_wb_valid;

    // The redirect wins over a stall. An in-flight long op is older than
    // the branch, so it is never cancelled.
    assign stall   = lu || sb || st;
    assign stall_f = stall && !pc_src_e;
    assign stall_d = stall && !pc_src_e;
    assign flush_d = pc_src_e;
    assign flush_e = stall || pc_src_e;

    // The structural stall means a start should never arrive mid-op.
    always_ff @(posedge clk) begin
        if (rst_n)
            assert (!(muldiv_start_e && muldiv_busy && cnt != '0));
    end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
module tb_hazard_scoreboard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       uses_rs1_d, uses_rs2_d, reg_write_d, muldiv_d;
    logic       mem_read_e, muldiv_start_e, reg_write_m, reg_write_w, pc_src_e;
    logic [1:0] forward_a, forward_b;
    logic       stall_f, stall_d, flush_d, flush_e;
    logic       muldiv_busy, muldiv_wb_valid;
    logic [4:0] muldiv_wb_rd;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_scoreboard_unit #(.REG_ADDR_W(5), .NUM_REGS(32), .MULDIV_LAT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .uses_rs1_d(uses_rs1_d), .uses_rs2_d(uses_rs2_d),
        .rd_d(rd_d), .reg_write_d(reg_write_d), .muldiv_d(muldiv_d),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .mem_read_e(mem_read_e),
        .muldiv_start_e(muldiv_start_e), .rd_m(rd_m), .reg_write_m(reg_write_m),
        .rd_w(rd_w), .reg_write_w(reg_write_w), .pc_src_e(pc_src_e),
        .forward_a(forward_a), .forward_b(forward_b),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .muldiv_busy(muldiv_busy), .muldiv_wb_valid(muldiv_wb_valid),
        .muldiv_wb_rd(muldiv_wb_rd)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rs1_d = 0; rs2_d = 0; rd_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0;
        rd_m = 0; rd_w = 0; uses_rs1_d = 0; uses_rs2_d = 0; reg_write_d = 0;
        muldiv_d = 0; mem_read_e = 0; muldiv_start_e = 0; reg_write_m = 0;
        reg_write_w = 0; pc_src_e = 0;
    endtask

    // Issues a long op with destination rd in the current cycle. On return,
    // the bench is in cycle 1 of that op with all inputs idle.
    task automatic issue(input logic [4:0] rd);
        muldiv_start_e = 1; rd_e = rd;
        step();
        idle_inputs();
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        step(); step();
        n_checks++;
        if ({muldiv_busy, muldiv_wb_valid} !== 2'b00) begin
            n_fail++; $display("FAIL reset_busy_wb: got %b want 00", {muldiv_busy, muldiv_wb_valid});
        end
        n_checks++;
        if (muldiv_wb_rd !== 5'd0) begin
            n_fail++; $display("FAIL reset_wb_rd: got %0d want 0", muldiv_wb_rd);
        end
        n_checks++;
        if ({forward_a, forward_b, stall_f, stall_d, flush_d, flush_e} !== 8'h00) begin
            n_fail++; $display("FAIL reset_comb: got %b want 00000000",
                               {forward_a, forward_b, stall_f, stall_d, flush_d, flush_e});
        end
        rst_n = 1;
        step();
    endtask

    task automatic test_forward();
        idle_inputs();
        rd_m = 5; reg_write_m = 1; rd_w = 5; reg_write_w = 1; rs1_e = 5; rs2_e = 0;
        #1;
        n_checks++;
        if ({forward_a, forward_b} !== 4'b1000) begin
            n_fail++; $display("FAIL fwd_mem_prio: got a=%b b=%b want a=10 b=00", forward_a, forward_b);
        end
        reg_write_m = 0;
        #1;
        n_checks++;
        if (forward_a !== 2'b01) begin
            n_fail++; $display("FAIL fwd_wb: got %b want 01", forward_a);
        end
        rd_m = 0; reg_write_m = 1; rd_w = 0; reg_write_w = 1; rs1_e = 0; rs2_e = 0;
        #1;
        n_checks++;
        if ({forward_a, forward_b} !== 4'b0000) begin
            n_fail++; $display("FAIL fwd_x0: got a=%b b=%b want 00 00", forward_a, forward_b);
        end
        rd_m = 3; rd_w = 4; rs1_e = 4; rs2_e = 3;
        #1;
        n_checks++;
        if ({forward_a, forward_b} !== 4'b0110) begin
            n_fail++; $display("FAIL fwd_split: got a=%b b=%b want a=01 b=10", forward_a, forward_b);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_load_use();
        idle_inputs();
        mem_read_e = 1; rd_e = 7; rs2_d = 7; uses_rs2_d = 1;
        #1;
        n_checks++;
        if ({stall_f, stall_d, flush_e, flush_d} !== 4'b1110) begin
            n_fail++; $display("FAIL lu_hit: got f/d/e/fd=%b want 1110", {stall_f, stall_d, flush_e, flush_d});
        end
        uses_rs2_d = 0;
        #1;
        n_checks++;
        if ({stall_f, stall_d, flush_e, flush_d} !== 4'b0000) begin
            n_fail++; $display("FAIL lu_unused: got %b want 0000", {stall_f, stall_d, flush_e, flush_d});
        end
        rd_e = 0; rs1_d = 0; uses_rs1_d = 1;
        #1;
        n_checks++;
        if (stall_d !== 1'b0) begin
            n_fail++; $display("FAIL lu_x0: got %b want 0", stall_d);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_long_op();
        logic exp_busy, exp_wb, exp_stall;
        idle_inputs();
        uses_rs1_d = 1; rs1_d = 9;
        #1;
        n_checks++;
        if (stall_d !== 1'b0) begin
            n_fail++; $display("FAIL long_c0_stall: got %b want 0", stall_d);
        end
        issue(9);
        for (int c = 1; c <= 5; c++) begin
            uses_rs1_d = 1; rs1_d = 9;
            #1;
            exp_busy  = (c <= 4);
            exp_wb    = (c == 4);
            exp_stall = (c <= 4);
            n_checks++;
            if ({muldiv_busy, muldiv_wb_valid, stall_d} !== {exp_busy, exp_wb, exp_stall}) begin
                n_fail++; $display("FAIL long_c%0d busy/wb/stall: got %b want %b", c,
                                   {muldiv_busy, muldiv_wb_valid, stall_d}, {exp_busy, exp_wb, exp_stall});
            end
            if (c == 4) begin
                n_checks++;
                if (muldiv_wb_rd !== 5'd9) begin
                    n_fail++; $display("FAIL long_wb_rd: got %0d want 9", muldiv_wb_rd);
                end
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic exp_busy, exp_wb, exp_stall;
        idle_inputs();
        issue(9);
        for (int c = 1; c <= 9; c++) begin
            muldiv_d       = (c <= 4);
            uses_rs1_d     = (c >= 5);
            rs1_d          = 9;
            muldiv_start_e = (c == 4);
            rd_e           = (c == 4) ? 5'd9 : 5'd0;
            #1;
            exp_busy  = (c <= 8);
            exp_wb    = (c == 4) || (c == 8);
            exp_stall = (c <= 3) || (c >= 5 && c <= 8);
            n_checks++;
            if ({muldiv_busy, muldiv_wb_valid, stall_d} !== {exp_busy, exp_wb, exp_stall}) begin
                n_fail++; $display("FAIL b2b_c%0d busy/wb/stall: got %b want %b", c,
                                   {muldiv_busy, muldiv_wb_valid, stall_d}, {exp_busy, exp_wb, exp_stall});
            end
            if (exp_wb) begin
                n_checks++;
                if (muldiv_wb_rd !== 5'd9) begin
                    n_fail++; $display("FAIL b2b_wb_rd_c%0d: got %0d want 9", c, muldiv_wb_rd);
                end
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_restart_other_rd();
        int waited;
        idle_inputs();
        issue(9);
        step(); step(); step();
        muldiv_start_e = 1; rd_e = 10;
        #1;
        n_checks++;
        if (muldiv_wb_valid !== 1'b1) begin
            n_fail++; $display("FAIL restart_pulse: got %b want 1", muldiv_wb_valid);
        end
        step();
        idle_inputs();
        uses_rs1_d = 1; rs1_d = 9;
        #1;
        n_checks++;
        if (stall_d !== 1'b0) begin
            n_fail++; $display("FAIL restart_old_clear: got %b want 0", stall_d);
        end
        uses_rs1_d = 0; uses_rs2_d = 1; rs2_d = 10;
        #1;
        n_checks++;
        if ({stall_d, muldiv_wb_rd} !== {1'b1, 5'd10}) begin
            n_fail++; $display("FAIL restart_new_pend: got stall=%b rd=%0d want stall=1 rd=10",
                               stall_d, muldiv_wb_rd);
        end
        idle_inputs();
        waited = 0;
        while (muldiv_busy === 1'b1 && waited < 10) begin
            step();
            waited++;
        end
        n_checks++;
        if (waited != 4) begin
            n_fail++; $display("FAIL restart_drain: got %0d cycles want 4", waited);
        end
    endtask

    task automatic test_branch_during_stall();
        idle_inputs();
        issue(3);
        mem_read_e = 1; rd_e = 7; uses_rs2_d = 1; rs2_d = 7; pc_src_e = 1;
        #1;
        n_checks++;
        if ({stall_f, stall_d, flush_d, flush_e, muldiv_busy} !== 5'b00111) begin
            n_fail++; $display("FAIL branch_dominates: got f/d/fd/fe/busy=%b want 00111",
                               {stall_f, stall_d, flush_d, flush_e, muldiv_busy});
        end
        step();
        idle_inputs();
        reg_write_d = 1; rd_d = 3;
        #1;
        n_checks++;
        if ({stall_d, flush_d, flush_e} !== 3'b101) begin
            n_fail++; $display("FAIL waw_stall: got d/fd/fe=%b want 101", {stall_d, flush_d, flush_e});
        end
        step();
        idle_inputs();
        step();
        n_checks++;
        if ({muldiv_wb_valid, muldiv_wb_rd} !== {1'b1, 5'd3}) begin
            n_fail++; $display("FAIL branch_op_completes: got v=%b rd=%0d want v=1 rd=3",
                               muldiv_wb_valid, muldiv_wb_rd);
        end
        step();
    endtask

    task automatic test_x0_dest();
        idle_inputs();
        issue(0);
        reg_write_d = 1; rd_d = 0; uses_rs1_d = 1; rs1_d = 0;
        #1;
        n_checks++;
        if ({muldiv_busy, stall_d} !== 2'b10) begin
            n_fail++; $display("FAIL x0_never_pending: got busy/stall=%b want 10", {muldiv_busy, stall_d});
        end
        idle_inputs();
        step(); step(); step();
        n_checks++;
        if ({muldiv_wb_valid, muldiv_wb_rd} !== {1'b1, 5'd0}) begin
            n_fail++; $display("FAIL x0_pulse: got v=%b rd=%0d want v=1 rd=0", muldiv_wb_valid, muldiv_wb_rd);
        end
        step();
    endtask

    task automatic test_reset_mid_op();
        int pulses;
        idle_inputs();
        issue(9);
        step();
        uses_rs1_d = 1; rs1_d = 9; rst_n = 0;
        #1;
        n_checks++;
        if (stall_d !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_pre: got %b want 1", stall_d);
        end
        step();
        rst_n = 1;
        #1;
        n_checks++;
        if ({muldiv_busy, muldiv_wb_valid, stall_d} !== 3'b000) begin
            n_fail++; $display("FAIL rst_mid_post: got busy/wb/stall=%b want 000",
                               {muldiv_busy, muldiv_wb_valid, stall_d});
        end
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            if (muldiv_wb_valid === 1'b1) pulses++;
            step();
        end
        n_checks++;
        if (pulses != 0) begin
            n_fail++; $display("FAIL rst_mid_no_pulse: got %0d pulses want 0", pulses);
        end
        idle_inputs();
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        test_reset();
        test_forward();
        test_load_use();
        test_long_op();
        test_back_to_back();
        test_restart_other_rd();
        test_branch_during_stall();
        test_x0_dest();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
